// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/hold control for a 5-stage pipeline with memory-wait timeout and perf counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    state_t state;
    logic [WW-1:0] wait_cnt;
    logic uses_rt, load_use, mem_stall, hold, flush, lu;
    always_comb begin
        uses_rt = id_opcode inside {6'b000000, 6'b101011, 6'b000100};
        load_use = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
        mem_stall = mem_req & ~mem_ready & (state != ERROR);
        // reset forces the free-running defaults regardless of state or hazards
        hold = ~rst & (mem_stall | (state == ERROR));
        flush = ~rst & ~hold & ex_branch_taken;
        lu = ~rst & ~hold & ~ex_branch_taken & load_use;
        pc_write = ~hold & ~lu;
        ifid_write = ~hold & ~lu;
        ifid_flush = flush;
        idex_bubble = flush | lu;
        pipe_hold = hold;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wait_cnt <= '0;
            mem_err <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                RUN: if (mem_stall) begin
                    state <= MEM_WAIT;
                    wait_cnt <= '0;
                end
                MEM_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (mem_ready) state <= RUN;
                    else if (WW'(wait_cnt + 1'b1) == WW'(MEM_TIMEOUT)) begin
                        state <= ERROR;
                        mem_err <= 1'b1;
                    end
                end
                default: state <= ERROR;
            endcase
            if (!pc_write && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors plus multi-cycle sequences checked through an expected-value queue
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [4:0] NONE = 5'b11000, LU = 5'b00010, BR = 5'b11110, MS = 5'b00001;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic ex_memread = 0, ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    typedef struct {
        string name;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic mr;
        logic [4:0] xrt;
        logic br, req, rdy;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[14];
    vec_t q[$];
    int total = 0, passed = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(string n, logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic mr,
                                logic [4:0] xrt, logic br, logic req, logic rdy, logic [4:0] exp);
        return '{n, op, rs, rt, mr, xrt, br, req, rdy, exp};
    endfunction

    task automatic chk(string n, int act, int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        else passed++;
    endtask

    task automatic cyc(vec_t v);
        vec_t e;
        id_opcode = v.op; id_rs = v.rs; id_rt = v.rt; ex_memread = v.mr; ex_rt = v.xrt;
        ex_branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
        q.push_back(v);
        @(negedge clk);
        e = q.pop_front();
        chk(e.name, int'({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}), int'(e.exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(mk("rst_outputs", 6'd0, 5'd5, 5'd5, 1, 5'd5, 1, 1, 0, NONE));
        rst = 1'b0;
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);
        chk("rst_mem_err", int'(mem_err), 0);
    endtask

    initial begin
        vec_t idle;
        idle = mk("idle", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, NONE);
        tbl[0]  = mk("lu_rs_rtype",   6'b000000, 5'd5, 5'd3, 1, 5'd5, 0, 0, 0, LU);
        tbl[1]  = mk("no_memread",    6'b000000, 5'd5, 5'd3, 0, 5'd5, 0, 0, 0, NONE);
        tbl[2]  = mk("rt_zero",       6'b000000, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, NONE);
        tbl[3]  = mk("addi_rt",       6'b001000, 5'd2, 5'd7, 1, 5'd7, 0, 0, 0, NONE);
        tbl[4]  = mk("sw_rt",         6'b101011, 5'd1, 5'd7, 1, 5'd7, 0, 0, 0, LU);
        tbl[5]  = mk("beq_rt",        6'b000100, 5'd1, 5'd9, 1, 5'd9, 0, 0, 0, LU);
        tbl[6]  = mk("lw_rt",         6'b100011, 5'd1, 5'd9, 1, 5'd9, 0, 0, 0, NONE);
        tbl[7]  = mk("lw_rs",         6'b100011, 5'd9, 5'd2, 1, 5'd9, 0, 0, 0, LU);
        tbl[8]  = mk("br_and_lu",     6'b000000, 5'd5, 5'd3, 1, 5'd5, 1, 0, 0, BR);
        tbl[9]  = mk("br_only",       6'b000000, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0, BR);
        tbl[10] = mk("ms_over_all",   6'b000000, 5'd5, 5'd3, 1, 5'd5, 1, 1, 0, MS);
        tbl[11] = mk("lu_after_ready",6'b000000, 5'd5, 5'd3, 1, 5'd5, 0, 1, 1, LU);
        tbl[12] = mk("req_ready",     6'b000000, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, NONE);
        tbl[13] = mk("lu_rt_rtype",   6'b000000, 5'd1, 5'd12, 1, 5'd12, 0, 0, 0, LU);

        @(posedge clk); #1;
        do_reset();
        foreach (tbl[i]) cyc(tbl[i]);
        chk("tbl_stall_cnt", int'(stall_cnt), 7);
        chk("tbl_flush_cnt", int'(flush_cnt), 2);

        do_reset();
        cyc(tbl[0]);
        cyc(idle);
        chk("lu_once_stall_cnt", int'(stall_cnt), 1);

        do_reset();
        cyc(tbl[8]);
        cyc(idle);
        chk("br_lu_flush_cnt", int'(flush_cnt), 1);
        chk("br_lu_stall_cnt", int'(stall_cnt), 0);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(mk("wait3_hold", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, MS));
        cyc(mk("wait3_release", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, NONE));
        cyc(idle);
        chk("wait3_mem_err", int'(mem_err), 0);
        chk("wait3_stall_cnt", int'(stall_cnt), 3);

        do_reset();
        for (int i = 0; i < TO; i++) cyc(mk("to_hold", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, MS));
        chk("to_not_yet_err", int'(mem_err), 0);
        cyc(mk("to_last_hold", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, MS));
        chk("to_mem_err", int'(mem_err), 1);
        cyc(mk("err_hold", 6'd0, 5'd1, 5'd2, 0, 5'd0, 1, 0, 1, MS));
        cyc(mk("err_hold_lu", 6'd0, 5'd5, 5'd2, 1, 5'd5, 0, 1, 1, MS));
        chk("err_stall_cnt", int'(stall_cnt), TO + 3);
        chk("err_sticky", int'(mem_err), 1);
        do_reset();
        cyc(mk("after_err_run", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, NONE));

        for (int i = 0; i < 2; i++) cyc(mk("mid_wait_hold", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, MS));
        do_reset();
        for (int i = 0; i < TO - 1; i++) cyc(mk("fresh_wait", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, MS));
        cyc(mk("fresh_release", 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, NONE));
        chk("fresh_mem_err", int'(mem_err), 0);

        do_reset();
        for (int i = 0; i < 20; i++) cyc(tbl[0]);
        chk("stall_saturate", int'(stall_cnt), 15);
        for (int i = 0; i < 20; i++) cyc(tbl[9]);
        chk("flush_saturate", int'(flush_cnt), 15);
        chk("stall_still_sat", int'(stall_cnt), 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
